// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and sequencing controller for the 5-stage pipeline.
// Produces PC / IF/ID / ID/EX write enables and flushes plus the hold for the
// back end, resolving load-use hazards, mispredicts and data-memory stalls,
// and keeps stall / flush performance counters.
module pipe_ctrl #(
   parameter int REGBITS = 4,
   parameter int CNTBITS = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [REGBITS-1:0] id_rs1,
   input  logic [REGBITS-1:0] id_rs2,
   input  logic               id_use_rs1,
   input  logic               id_use_rs2,
   input  logic               ex_is_load,
   input  logic [REGBITS-1:0] ex_rd,
   input  logic               ex_mispredict,
   input  logic               mem_busy,
   output logic               pc_wrt_en,
   output logic               if_wrt_en,
   output logic               if_flush,
   output logic               id_flush,
   output logic               pipe_hold,
   output logic [CNTBITS-1:0] stall_cnt,
   output logic [CNTBITS-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   state_t state_q, state_d;
   state_t ret_state_q, ret_state_d;
   state_t eff_state;
   logic   lu;
   logic   flush_take;
   logic [CNTBITS-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNTBITS-1:0] flush_cnt_q, flush_cnt_d;

   // Once memory releases, MEM_WAIT behaves exactly like the state it interrupted.
   assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

   // Load-use: EX load writes a nonzero register that ID actually reads.
   assign lu = ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   // State, return-state and counter registers with synchronous reset folded into _d.
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end

   // Next-state: reset beats memory wait, which beats mispredict; load-use never moves the FSM.
   always_comb begin
      state_d     = RUN;
      ret_state_d = ret_state_q;
      if (reset) begin
         state_d     = RUN;
         ret_state_d = RUN;
      end else if (mem_busy) begin
         state_d = MEM_WAIT;
         if (state_q != MEM_WAIT) begin
            ret_state_d = state_q;
         end
      end else if (eff_state == FLUSH) begin
         state_d = RUN;
      end else if (ex_mispredict) begin
         state_d = FLUSH;
      end else begin
         state_d = RUN;
      end
   end

   // Mealy control outputs; FLUSH ignores mispredict and load-use since ID/EX hold bubbles.
   always_comb begin
      pc_wrt_en  = 1'b1;
      if_wrt_en  = 1'b1;
      if_flush   = 1'b0;
      id_flush   = 1'b0;
      pipe_hold  = 1'b0;
      flush_take = 1'b0;
      if (reset) begin
         pc_wrt_en = 1'b0;
         if_wrt_en = 1'b0;
         if_flush  = 1'b1;
         id_flush  = 1'b1;
      end else if (mem_busy) begin
         pc_wrt_en = 1'b0;
         if_wrt_en = 1'b0;
         pipe_hold = 1'b1;
      end else if (eff_state == FLUSH) begin
         pc_wrt_en = 1'b1;
      end else if (ex_mispredict) begin
         if_flush   = 1'b1;
         id_flush   = 1'b1;
         flush_take = 1'b1;
      end else if (lu) begin
         pc_wrt_en = 1'b0;
         if_wrt_en = 1'b0;
         id_flush  = 1'b1;
      end
   end

   // Performance counters: stalls are non-reset cycles with the PC frozen; both wrap naturally.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (reset) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!pc_wrt_en) begin
            stall_cnt_d = stall_cnt_q + CNTBITS'(1);
         end
         if (flush_take) begin
            flush_cnt_d = flush_cnt_q + CNTBITS'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors for pipe_ctrl with a scoreboard queue.
// The driver pushes the hand-computed response for each cycle; a monitor on
// the falling edge pops and compares against what the controller presents.
module tb_pipe_ctrl;

   localparam int REGBITS = 4;
   localparam int CNTBITS = 4;

   // {pc_wrt_en, if_wrt_en, if_flush, id_flush, pipe_hold}
   localparam logic [4:0] RST = 5'b00110;
   localparam logic [4:0] NRM = 5'b11000;
   localparam logic [4:0] LUS = 5'b00010;
   localparam logic [4:0] MPR = 5'b11110;
   localparam logic [4:0] MWT = 5'b00001;

   typedef struct {
      string              name;
      logic [4:0]         ctl;
      logic [CNTBITS-1:0] sc;
      logic [CNTBITS-1:0] fc;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [REGBITS-1:0] id_rs1 = '0;
   logic [REGBITS-1:0] id_rs2 = '0;
   logic               id_use_rs1 = 1'b0;
   logic               id_use_rs2 = 1'b0;
   logic               ex_is_load = 1'b0;
   logic [REGBITS-1:0] ex_rd = '0;
   logic               ex_mispredict = 1'b0;
   logic               mem_busy = 1'b0;
   logic               pc_wrt_en, if_wrt_en, if_flush, id_flush, pipe_hold;
   logic [CNTBITS-1:0] stall_cnt, flush_cnt;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   pipe_ctrl #(.REGBITS(REGBITS), .CNTBITS(CNTBITS)) dut (
      .clk(clk), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .ex_mispredict(ex_mispredict), .mem_busy(mem_busy),
      .pc_wrt_en(pc_wrt_en), .if_wrt_en(if_wrt_en),
      .if_flush(if_flush), .id_flush(id_flush), .pipe_hold(pipe_hold),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Drive one cycle of inputs just after the edge and queue the expected response.
   task automatic applyStimulus(input string name, input logic rst,
                                input logic [REGBITS-1:0] rs1, input logic [REGBITS-1:0] rs2,
                                input logic u1, input logic u2, input logic ld,
                                input logic [REGBITS-1:0] rd, input logic mp, input logic mb,
                                input logic [4:0] ctl, input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_is_load = ld; ex_rd = rd; ex_mispredict = mp; mem_busy = mb;
      e.name = name; e.ctl = ctl; e.sc = CNTBITS'(sc); e.fc = CNTBITS'(fc);
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      logic [4:0] act;
      act = {pc_wrt_en, if_wrt_en, if_flush, id_flush, pipe_hold};
      checks += 3;
      if (act !== e.ctl) begin
         errors++;
         $display("[TB] FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
      end
      if (stall_cnt !== e.sc) begin
         errors++;
         $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.sc);
      end
      if (flush_cnt !== e.fc) begin
         errors++;
         $display("[TB] FAIL %s flush_cnt: got %0d expected %0d", e.name, flush_cnt, e.fc);
      end
   endtask

   // Monitor: mid-cycle, compare the presented outputs with the oldest queued expectation.
   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         checkOutput(expQ.pop_front());
      end
   end

   // Directed sequence; each line is one cycle with its hand-derived response.
   initial begin
      int waitCnt;
      @(posedge clk);
      //            name          rst rs1 rs2 u1 u2 ld rd mp mb ctl  sc fc
      applyStimulus("rst1",       1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
      applyStimulus("rst2",       1, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0, 0);
      applyStimulus("postrst",    0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
      applyStimulus("lu_rs2",     0, 0, 5, 0, 1, 1, 5, 0, 0, LUS, 0, 0);
      applyStimulus("after_lu",   0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 0);
      applyStimulus("lu_rd0",     0, 0, 0, 0, 1, 1, 0, 0, 0, NRM, 1, 0);
      applyStimulus("lu_nouse",   0, 0, 5, 0, 0, 1, 5, 0, 0, NRM, 1, 0);
      applyStimulus("lu_rs1",     0, 3, 0, 1, 0, 1, 3, 0, 0, LUS, 1, 0);
      applyStimulus("mispred",    0, 0, 0, 0, 0, 0, 0, 1, 0, MPR, 2, 0);
      applyStimulus("flush_ign",  0, 3, 0, 1, 0, 1, 3, 1, 0, NRM, 2, 1);
      applyStimulus("run_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 2, 1);
      applyStimulus("mw1",        0, 0, 0, 0, 0, 0, 0, 1, 1, MWT, 2, 1);
      applyStimulus("mw2",        0, 0, 0, 0, 0, 0, 0, 1, 1, MWT, 3, 1);
      applyStimulus("mw3",        0, 0, 0, 0, 0, 0, 0, 1, 1, MWT, 4, 1);
      applyStimulus("mw_rel",     0, 0, 0, 0, 0, 0, 0, 1, 0, MPR, 5, 1);
      applyStimulus("fl_mw1",     0, 0, 0, 0, 0, 0, 0, 1, 1, MWT, 5, 2);
      applyStimulus("fl_mw2",     0, 0, 0, 0, 0, 0, 0, 1, 1, MWT, 6, 2);
      applyStimulus("fl_rel",     0, 0, 0, 0, 0, 0, 0, 1, 0, NRM, 7, 2);
      applyStimulus("mp_again",   0, 0, 0, 0, 0, 0, 0, 1, 0, MPR, 7, 2);
      applyStimulus("rst_flush",  1, 0, 0, 0, 0, 0, 0, 1, 0, RST, 7, 3);
      applyStimulus("clr_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
      applyStimulus("mw_pre",     0, 0, 0, 0, 0, 0, 0, 0, 1, MWT, 0, 0);
      applyStimulus("rst_mw",     1, 0, 0, 0, 0, 0, 0, 0, 1, RST, 1, 0);
      applyStimulus("post_rst2",  0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 0);
      for (int k = 0; k < 17; k++) begin
         applyStimulus($sformatf("wrap_lu%0d", k), 0, 0, 7, 0, 1, 1, 7, 0, 0, LUS, k % 16, 0);
      end
      applyStimulus("wrap_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 0);
      waitCnt = 0;
      while (expQ.size() > 0 && waitCnt < 10) begin
         @(posedge clk);
         waitCnt++;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It generates the write enables and flushes for the PC, the IF/ID register and the ID/EX register, and the hold signal for the later stages. It resolves:
- load-use hazards detected in ID,
- branch mispredictions resolved in EX,
- multi-cycle data-memory stalls.

It also keeps stall and flush performance counters. It sits beside the datapath: its outputs drive the `wrt_en` and the OR'd flush/reset inputs of the pipeline registers.

## Interface
- `REGBITS`, 4, register-index width
- `CNTBITS`, 32, performance counter width

- `clk`  in  1  pipeline clock
- `reset`  in  1  synchronous, active-high reset
- `id_rs1`, `id_rs2`  in  REGBITS  source register indices of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1  the instruction in ID actually reads rs1 / rs2
- `ex_is_load`  in  1  the instruction in EX is a load
- `ex_rd`  in  REGBITS  destination index of the instruction in EX
- `ex_mispredict`  in  1  branch/jump in EX resolved opposite to its IF prediction (or to a wrong target)
- `mem_busy`  in  1  data-memory access in MEM not yet complete
- `pc_wrt_en`  out  1  PC register write enable
- `if_wrt_en`  out  1  IF/ID register write enable
- `if_flush`  out  1  synchronous clear of IF/ID (zero = bubble)
- `id_flush`  out  1  synchronous clear of ID/EX (insert bubble)
- `pipe_hold`  out  1  freeze ID/EX, EX/MEM, MEM/WB
- `stall_cnt`  out  CNTBITS  cycles with `pc_wrt_en`=0 outside reset
- `flush_cnt`  out  CNTBITS  mispredict flushes taken

## Operation
- State register with three states: RUN, FLUSH, MEM_WAIT. A registered `ret_state` (RUN/FLUSH) records the state to resume after MEM_WAIT.
- Outputs are Mealy: a function of the state and the current inputs.
- Load-use hazard: `lu` = `ex_is_load` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- Priority in every state: `reset` > `mem_busy` > `ex_mispredict` > `lu`.
- `reset`=1:
  - Outputs: `pc_wrt_en`=0, `if_wrt_en`=0, `if_flush`=1, `id_flush`=1, `pipe_hold`=0.
  - Next state RUN; both counters cleared to 0.
  - Reset asserted mid-stall or mid-flush discards everything in flight.
- `mem_busy`=1 (any state):
  - Outputs: `pc_wrt_en`=0, `if_wrt_en`=0, `pipe_hold`=1, flushes 0.
  - Next state MEM_WAIT. On entry from RUN or FLUSH, `ret_state` takes the current state; while in MEM_WAIT, `ret_state` is unchanged.
  - A concurrent `ex_mispredict` is not acted on. EX is frozen, so the mispredict is re-presented after release.
- RUN, `ex_mispredict`:
  - Outputs: `pc_wrt_en`=1 (the PC mux selects the corrected target), `if_wrt_en`=1, `if_flush`=1, `id_flush`=1, `pipe_hold`=0.
  - `flush_cnt`+1; next state FLUSH.
- RUN, `lu`:
  - Outputs: `pc_wrt_en`=0, `if_wrt_en`=0, `id_flush`=1, `if_flush`=0, `pipe_hold`=0; stay in RUN.
  - The hazard clears naturally the next cycle because EX then holds the bubble.
- RUN, no event: `pc_wrt_en`=`if_wrt_en`=1, all other outputs 0.
- FLUSH:
  - ID and EX hold bubbles, so `ex_mispredict` and `lu` are ignored.
  - Outputs as RUN/no-event; next state RUN.
- MEM_WAIT with `mem_busy`=0: behave exactly as `ret_state` with the current inputs (full priority evaluation); next state follows from that evaluation.
- `stall_cnt` increments in every non-reset cycle with `pc_wrt_en`=0 (load-use and mem_busy cycles).
- Both counters wrap modulo 2^CNTBITS.

## Timing
- Control outputs are combinational from state and inputs: zero-cycle latency and valid in the same cycle as the hazard inputs. No combinational path exists from any output back to any input.
- Counters are registered: an event in cycle N is visible in the counter value in cycle N+1.
- A mispredict costs exactly 2 bubbles: the flushed IF/ID plus the flushed ID/EX.
- A load-use hazard costs exactly 1 stall cycle.
- A `mem_busy` pulse of k cycles holds the pipeline for k cycles. The pipeline advances in the first cycle with `mem_busy`=0.
- First cycle after `reset` deasserts: state RUN, `pc_wrt_en`=1 (absent other events).

## Test plan
- **Reset:** reset held 2 cycles, then released → during reset `if_flush`=`id_flush`=1, `pc_wrt_en`=0; after release `pc_wrt_en`=1, `stall_cnt`=`flush_cnt`=0.
- **Load-use on rs2:** `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1 for 1 cycle → `pc_wrt_en`=`if_wrt_en`=0, `id_flush`=1; next cycle normal; `stall_cnt`=1.
  - Repeat with `ex_rd`=0, or with `id_use_rs2`=0 → no stall.
- **Mispredict:** `ex_mispredict`=1 in RUN → `if_flush`=`id_flush`=1, `pc_wrt_en`=1. Next cycle state FLUSH: `ex_mispredict`=1 and `lu` are ignored. `flush_cnt`=1 after one cycle.
- **Memory wait:** `mem_busy`=1 for 3 cycles with `ex_mispredict`=1 throughout → 3 cycles `pipe_hold`=1, no flush. Cycle 4: flush taken, `flush_cnt`=1, `stall_cnt`=3.
- **Memory wait from FLUSH:** `mem_busy` rises during FLUSH → after release, one FLUSH-behaviour cycle in which `ex_mispredict` is still ignored, then RUN.
- **Counter wrap:** with CNTBITS=4, generate 17 load-use stalls → `stall_cnt`=1.
